// File: rtl/if_injector_n_if.sv
// Sample-stream bundle for if_injector_n: incoming benchmark samples and
// the registered (possibly corrupted) samples handed to trace capture.
interface if_injector_n_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;

    // Producer side: drives samples, observes the injector output
    modport master (output din, din_valid, input dout, dout_valid);
    // Injector side: consumes samples, drives the registered output
    modport slave  (input din, din_valid, output dout, dout_valid);
endinterface

// File: rtl/if_injector_n.sv
// Intermittent-fault injector: registers a WIDTH-bit sample stream and,
// on an LFSR-driven schedule, corrupts masked bits for bounded bursts.
// Optional logging (fault_count, last_fault_ts) is enabled by defining
// IF_INJ_LOG_EN; otherwise those ports are tied to zero.
module if_injector_n #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_mode,
    input  logic [WIDTH-1:0]  cfg_mask,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_burst,
    input  logic [7:0]        cfg_prob,
    input  logic              arm,
    if_injector_n_if.slave    bus,
    output logic              fault_active,
    output logic              busy,
    output logic [15:0]       fault_count,
    output logic [31:0]       last_fault_ts
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] TAPS     = 16'hB400;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_SA0 = 2'd1;
    localparam logic [1:0] MODE_SA1 = 2'd2;
    localparam logic [1:0] MODE_FLIP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  pcnt, pcnt_nxt;
    logic [CNT_W-1:0]  bcnt, bcnt_nxt;
    logic [15:0]       lfsr, lfsr_nxt;

    logic [1:0]        mode;
    logic [WIDTH-1:0]  mask;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  burst;
    logic [7:0]        prob;

    logic              cfg_load;
    logic [1:0]        mode_nxt;
    logic [CNT_W-1:0]  burst_eff;
    logic [WIDTH-1:0]  sample, sample_nxt;
    logic              sample_valid;
    logic              fault_active_nxt;
    logic              busy_nxt;

    assign bus.dout       = sample;
    assign bus.dout_valid = sample_valid;

    // Next-state, counter, LFSR and output-data decode
    always_comb begin
        state_nxt  = state;
        pcnt_nxt   = pcnt;
        bcnt_nxt   = bcnt;
        lfsr_nxt   = lfsr;
        sample_nxt = bus.din;
        cfg_load   = (state == ST_IDLE) && cfg_we;
        mode_nxt   = cfg_load ? cfg_mode : mode;
        burst_eff  = (burst == '0) ? CNT_W'(1) : burst;

        if (!arm) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_WAIT;
                    pcnt_nxt  = cfg_load ? cfg_period : period;
                end
                ST_WAIT: begin
                    if (pcnt != '0) begin
                        pcnt_nxt = pcnt - CNT_W'(1);
                    end else if (lfsr[7:0] < prob) begin
                        state_nxt = ST_ACTIVE;
                        bcnt_nxt  = burst_eff - CNT_W'(1);
                    end else begin
                        pcnt_nxt = period;
                    end
                end
                ST_ACTIVE: begin
                    if (bcnt == '0) begin
                        state_nxt = ST_WAIT;
                        pcnt_nxt  = period;
                    end else begin
                        bcnt_nxt = bcnt - CNT_W'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Galois LFSR runs only while the schedule is live
        if (state != ST_IDLE) begin
            lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);
        end

        // Corruption follows the state registered alongside this sample
        if (state == ST_ACTIVE) begin
            case (mode)
                MODE_SA0:  sample_nxt = bus.din & ~mask;
                MODE_SA1:  sample_nxt = bus.din | mask;
                MODE_FLIP: sample_nxt = bus.din ^ mask;
                default:   sample_nxt = bus.din;
            endcase
        end

        fault_active_nxt = (state_nxt == ST_ACTIVE) && (mode_nxt != MODE_OFF);
        busy_nxt         = (state_nxt != ST_IDLE);
    end

    // State, configuration, LFSR and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pcnt         <= '0;
            bcnt         <= '0;
            lfsr         <= SEED_EFF;
            mode         <= MODE_OFF;
            mask         <= '0;
            period       <= '0;
            burst        <= CNT_W'(1);
            prob         <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            fault_active <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            pcnt         <= pcnt_nxt;
            bcnt         <= bcnt_nxt;
            lfsr         <= lfsr_nxt;
            sample       <= sample_nxt;
            sample_valid <= bus.din_valid;
            fault_active <= fault_active_nxt;
            busy         <= busy_nxt;
            if (cfg_load) begin
                mode   <= cfg_mode;
                mask   <= cfg_mask;
                period <= cfg_period;
                burst  <= cfg_burst;
                prob   <= cfg_prob;
            end
        end
    end

`ifdef IF_INJ_LOG_EN
    logic [31:0] cycle;
    logic        activate;

    assign activate = (state == ST_WAIT) && (state_nxt == ST_ACTIVE);

    // Free-running cycle counter used as the fault timestamp base
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    // Saturating activation count and timestamp of the latest activation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_count   <= '0;
            last_fault_ts <= '0;
        end else if (activate) begin
            if (fault_count != 16'hFFFF) begin
                fault_count <= fault_count + 16'd1;
            end
            last_fault_ts <= cycle;
        end
    end
`else
    assign fault_count   = '0;
    assign last_fault_ts = '0;
`endif

endmodule

// File: tb/tb_if_injector_n.sv
// Randomized scoreboard bench for if_injector_n: a behavioural model
// predicts every post-edge output; a monitor compares one cycle later.
module tb_if_injector_n;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    localparam int S_IDLE = 0;
    localparam int S_WAIT = 1;
    localparam int S_ACT  = 2;

    typedef struct {
        logic [WIDTH-1:0] dout;
        logic             dv;
        logic             fa;
        logic             busy;
        logic [15:0]      cnt;
        logic [31:0]      ts;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic [1:0]       cfg_mode;
    logic [WIDTH-1:0] cfg_mask;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_burst;
    logic [7:0]       cfg_prob;
    logic             arm;
    logic             fault_active;
    logic             busy;
    logic [15:0]      fault_count;
    logic [31:0]      last_fault_ts;

    if_injector_n_if #(.WIDTH(WIDTH)) bus ();

    if_injector_n #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SEED(SEED)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .cfg_mode      (cfg_mode),
        .cfg_mask      (cfg_mask),
        .cfg_period    (cfg_period),
        .cfg_burst     (cfg_burst),
        .cfg_prob      (cfg_prob),
        .arm           (arm),
        .bus           (bus),
        .fault_active  (fault_active),
        .busy          (busy),
        .fault_count   (fault_count),
        .last_fault_ts (last_fault_ts)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    // Reference model: schedule expressed as "cycles until next check"
    // and "fault cycles remaining", plus the configuration in force.
    int          m_phase;
    int          m_to_check;
    int          m_fault_left;
    logic [15:0] m_lfsr;
    int          m_mode, m_period, m_burst, m_prob;
    logic [WIDTH-1:0] m_mask;
    longint      m_cycle;
    int          m_count;
    longint      m_ts;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [WIDTH-1:0] corrupt(input logic [WIDTH-1:0] d, input int mode,
                                                 input logic [WIDTH-1:0] msk);
        case (mode)
            1: return d & ~msk;
            2: return d | msk;
            3: return d ^ msk;
            default: return d;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = S_IDLE; m_to_check = 0; m_fault_left = 0;
        m_lfsr = (SEED == 16'h0) ? 16'h0001 : SEED;
        m_mode = 0; m_mask = '0; m_period = 0; m_burst = 1; m_prob = 0;
        m_cycle = 0; m_count = 0; m_ts = 0;
    endtask

    // Predict outputs after the coming edge from the current inputs
    task automatic model_edge();
        exp_t e;
        int   nxt;
        logic load;
        if (!rst_n) begin
            model_reset();
            e.dout = '0; e.dv = 1'b0; e.fa = 1'b0; e.busy = 1'b0; e.cnt = '0; e.ts = '0;
            q.push_back(e);
            return;
        end
        e.dout = (m_phase == S_ACT) ? corrupt(bus.din, m_mode, m_mask) : bus.din;
        e.dv   = bus.din_valid;
        load   = (m_phase == S_IDLE) && cfg_we;
        nxt    = m_phase;
        if (!arm) begin
            nxt = S_IDLE;
        end else if (m_phase == S_IDLE) begin
            nxt = S_WAIT;
            m_to_check = load ? int'(cfg_period) : m_period;
        end else if (m_phase == S_WAIT) begin
            if (m_to_check > 0) begin
                m_to_check--;
            end else if (int'(m_lfsr[7:0]) < m_prob) begin
                nxt = S_ACT;
                m_fault_left = (m_burst == 0) ? 1 : m_burst;
                if (m_count < 65535) m_count++;
                m_ts = m_cycle;
            end else begin
                m_to_check = m_period;
            end
        end else begin
            m_fault_left--;
            if (m_fault_left == 0) begin
                nxt = S_WAIT;
                m_to_check = m_period;
            end
        end
        if (m_phase != S_IDLE) m_lfsr = lfsr_step(m_lfsr);
        if (load) begin
            m_mode = int'(cfg_mode); m_mask = cfg_mask; m_period = int'(cfg_period);
            m_burst = int'(cfg_burst); m_prob = int'(cfg_prob);
        end
        m_cycle++;
        m_phase = nxt;
        e.fa   = (m_phase == S_ACT) && (m_mode != 0);
        e.busy = (m_phase != S_IDLE);
`ifdef IF_INJ_LOG_EN
        e.cnt = 16'(m_count);
        e.ts  = 32'(m_ts);
`else
        e.cnt = '0;
        e.ts  = '0;
`endif
        q.push_back(e);
    endtask

    // One clock of stimulus: predict, then advance to the next falling edge
    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit rand_din);
        for (int i = 0; i < n; i++) begin
            if (rand_din) begin
                bus.din       = WIDTH'($urandom);
                bus.din_valid = 1'($urandom);
            end
            step();
        end
    endtask

    task automatic load_cfg(input int mode, input logic [WIDTH-1:0] msk, input int per,
                            input int bst, input int prb);
        arm = 1'b0; cfg_we = 1'b0;
        step();
        cfg_we = 1'b1; arm = 1'b1;
        cfg_mode = 2'(mode); cfg_mask = msk; cfg_period = CNT_W'(per);
        cfg_burst = CNT_W'(bst); cfg_prob = 8'(prb);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare every registered output one step after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dout",          32'(bus.dout),      32'(e.dout));
                chk("dout_valid",    32'(bus.dout_valid), 32'(e.dv));
                chk("fault_active",  32'(fault_active),  32'(e.fa));
                chk("busy",          32'(busy),          32'(e.busy));
                chk("fault_count",   32'(fault_count),   32'(e.cnt));
                chk("last_fault_ts", last_fault_ts,      e.ts);
            end
        end
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; arm = 1'b0;
        cfg_mode = '0; cfg_mask = '0; cfg_period = '0; cfg_burst = '0; cfg_prob = '0;
        bus.din = '0; bus.din_valid = 1'b0;
        model_reset();
        @(negedge clk);
        run(3, 1'b1);
        rst_n = 1'b1;

        // Pass-through with mode 0
        cfg_we = 1'b1; cfg_mode = 2'd0; cfg_mask = 4'hF; cfg_prob = 8'd255; arm = 1'b1;
        bus.din = 4'hA; bus.din_valid = 1'b1;
        step();
        cfg_we = 1'b0; bus.din_valid = 1'b0;
        run(20, 1'b1);

        // Always-fire stuck-at-1 on bits 0 and 2, din held at 0
        load_cfg(2, 4'b0101, 0, 3, 255);
        bus.din = 4'h0; bus.din_valid = 1'b1;
        run(40, 1'b0);

        // Never-fire with period 2
        load_cfg(1, 4'hF, 2, 4, 0);
        run(200, 1'b1);

        // Bit-flip with burst 0 (single-cycle bursts)
        load_cfg(3, 4'hF, 3, 0, 128);
        run(80, 1'b1);

        // Config writes while busy must be ignored
        for (int i = 0; i < 20; i++) begin
            cfg_we = 1'b1; cfg_mode = 2'($urandom); cfg_mask = WIDTH'($urandom);
            cfg_period = CNT_W'($urandom); cfg_burst = CNT_W'($urandom); cfg_prob = 8'($urandom);
            run(1, 1'b1);
        end
        cfg_we = 1'b0;

        // Disarm in the middle of a 10-cycle burst
        load_cfg(1, 4'hF, 0, 10, 255);
        for (int i = 0; i < 80 && !(m_phase == S_ACT && m_fault_left == 6); i++) run(1, 1'b1);
        arm = 1'b0;
        run(4, 1'b1);

        // Reset in the middle of a 10-cycle burst
        load_cfg(2, 4'hF, 0, 10, 255);
        for (int i = 0; i < 80 && !(m_phase == S_ACT && m_fault_left == 6); i++) run(1, 1'b1);
        rst_n = 1'b0;
        run(1, 1'b1);
        rst_n = 1'b1; arm = 1'b0;
        run(3, 1'b1);

        // Randomized traffic: config, arming and occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 39) == 0) arm = ~arm;
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_mode   = 2'($urandom);
            cfg_mask   = WIDTH'($urandom);
            cfg_period = CNT_W'($urandom_range(0, 5));
            cfg_burst  = CNT_W'($urandom_range(0, 4));
            cfg_prob   = 8'($urandom);
            run(1, 1'b1);
        end
        rst_n = 1'b1; cfg_we = 1'b0;
        run(5, 1'b1);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
